conv1x1_1cycle: RTL and testbench
=================================

Name: conv1x1_1cycle

Overview:
- Single-tap (1x1) convolution datapath: y = x*w + b, registered with exactly one clock cycle of latency.
- Carries a valid qualifier alongside the data.
- Used as the baseline, unpipelined multiply-accumulate element in the convolution Fmax study. Multiply and add complete in one register stage.

Parameters:
- WIDTH, 16, bit width of operands x, w and b; result width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  qualifies x, w and b in the current cycle
- x  input  WIDTH  unsigned activation operand
- w  input  WIDTH  unsigned weight operand
- b  input  WIDTH  unsigned bias operand
- y  output  2*WIDTH  registered result x*w + b
- valid_out  output  1  high for one cycle when y holds a new result

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset:
  - rst_n low forces y=0 and valid_out=0 immediately, independent of clk.
  - Outputs stay 0 while rst_n is low. Normal operation resumes on the first rising clk edge after rst_n goes high.
  - Reset mid-operation discards any in-flight result; valid_out does not assert for it.
- Arithmetic:
  - All operands are unsigned.
  - Product x*w is full 2*WIDTH bits. b is zero-extended to 2*WIDTH and added.
  - Maximum value is (2^WIDTH-1)^2 + (2^WIDTH-1) = 2^(2*WIDTH) - 2^WIDTH, so no overflow or truncation is possible and no carry-out is needed.
- Latency and throughput:
  - On each rising clk edge where valid_in=1, x, w and b are sampled. y <= x*w + b and valid_out <= 1 take effect at that same edge. The result is visible one cycle after presentation.
  - Full throughput: a new operand set is accepted every cycle. Back-to-back valid_in produces back-to-back valid_out with results in input order.
  - No stall or backpressure; there is no ready signal.
- Idle:
  - On a rising edge with valid_in=0, valid_out <= 0.
  - y holds its last computed value; it is not cleared and not recomputed.
- Operand values while valid_in=0 are ignored and must not change y.
- valid_out is a pure registered copy of valid_in. Its pulse width equals the number of consecutive valid input cycles.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: drive rst_n=0 with valid_in=1, x=3, w=4, b=5 and toggle clk -> y=0 and valid_out=0 throughout. Assert rst_n asynchronously between edges -> outputs clear without waiting for an edge.
- Single pulse (b=5): valid_in=1, x=3, w=4 for one edge, then valid_in=0 -> after that edge y=17 and valid_out=1. After the next edge valid_out=0 and y stays 17.
- Back-to-back (b=5): present (x=2,w=7) then (x=1,w=9) on consecutive edges, then valid_in=0 -> y=19 with valid_out=1, next cycle y=14 with valid_out=1, then valid_out=0 with y held at 14.
- Idle hold: with valid_in=0, change x=100, w=200, b=7 over 3 edges -> y unchanged and valid_out=0.
- Max operands (WIDTH=16): x=w=b=16'hFFFF with valid_in=1 -> y=32'hFFFF0000 and valid_out=1, with no wrap.
- Reset mid-stream: valid_in=1 with x=5, w=6, b=1 on edge N, pull rst_n low before edge N+1 -> y=0 and valid_out=0. After release with valid_in=0, valid_out stays 0.

Source files
------------

// File: rtl/conv1x1_1cycle.sv
// Single-tap 1x1 convolution element: y = x*w + b with one register stage.
// Multiply and add share a single cycle. This is the unpipelined baseline MAC.
// valid_out is a registered copy of valid_in.
// y holds its last result while no valid operands arrive.
module conv1x1_1cycle #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_in,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     w,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   y,
   output logic                 valid_out
);

   logic [2*WIDTH-1:0] x_ext;
   logic [2*WIDTH-1:0] w_ext;
   logic [2*WIDTH-1:0] b_ext;
   logic [2*WIDTH-1:0] mac;

   logic [2*WIDTH-1:0] y_d;
   logic [2*WIDTH-1:0] y_q;
   logic               valid_d;
   logic               valid_q;

   // Zero-extend operands so the full-width product and sum cannot wrap.
   always_comb begin
      x_ext = {{WIDTH{1'b0}}, x};
      w_ext = {{WIDTH{1'b0}}, w};
      b_ext = {{WIDTH{1'b0}}, b};
      mac   = (x_ext * w_ext) + b_ext;
   end

   // Next state: capture a new result only on valid input, otherwise hold y.
   always_comb begin
      y_d     = y_q;
      valid_d = valid_in;
      if (valid_in) begin
         y_d = mac;
      end
   end

   // Result and qualifier registers; reset clears both without waiting for clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         y_q     <= y_d;
         valid_q <= valid_d;
      end
   end

   assign y         = y_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_conv1x1_1cycle.sv
// Self-checking bench for conv1x1_1cycle: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_conv1x1_1cycle;

   localparam int unsigned WIDTH = 16;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               valid_in;
   logic [WIDTH-1:0]   x;
   logic [WIDTH-1:0]   w;
   logic [WIDTH-1:0]   b;
   logic [2*WIDTH-1:0] y;
   logic               valid_out;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural expectation: the most recent accepted result and whether the
   // previous edge accepted an operand set.
   longint unsigned m_y;
   logic            m_v;

   conv1x1_1cycle #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .x         (x),
      .w         (w),
      .b         (b),
      .y         (y),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint unsigned act,
                        input longint unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: result = x*w + b in plain 64-bit arithmetic.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_y <= 0;
         m_v <= 1'b0;
      end else begin
         m_v <= valid_in;
         if (valid_in) begin
            m_y <= longint'(x) * longint'(w) + longint'(b);
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      check("model_y", longint'(y), m_y);
      check("model_valid", longint'(valid_out), longint'(m_v));
   end

   task automatic expect_out(input string name, input longint unsigned ey, input logic ev);
      check({name, "_y"}, longint'(y), ey);
      check({name, "_valid"}, longint'(valid_out), longint'(ev));
   endtask

   task automatic edge_then;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held with live operands: outputs must stay zero across edges.
      rst_n = 1'b0; valid_in = 1'b1; x = 3; w = 4; b = 5;
      repeat (3) edge_then();
      expect_out("reset_hold", 0, 1'b0);

      // Single pulse.
      @(negedge clk);
      rst_n = 1'b1;
      edge_then();
      expect_out("single", 17, 1'b1);
      valid_in = 1'b0;
      edge_then();
      expect_out("single_after", 17, 1'b0);

      // Back-to-back operands, results in order.
      valid_in = 1'b1; x = 2; w = 7; b = 5;
      edge_then();
      expect_out("b2b_first", 19, 1'b1);
      x = 1; w = 9;
      edge_then();
      expect_out("b2b_second", 14, 1'b1);
      valid_in = 1'b0;
      edge_then();
      expect_out("b2b_after", 14, 1'b0);

      // Idle operand changes must not disturb y.
      x = 100; w = 200; b = 7;
      for (int i = 0; i < 3; i++) begin
         edge_then();
         expect_out("idle_hold", 14, 1'b0);
         x = x + 1;
      end

      // Maximum operands: no wrap.
      valid_in = 1'b1; x = 16'hFFFF; w = 16'hFFFF; b = 16'hFFFF;
      edge_then();
      expect_out("max", 64'h0000_0000_FFFF_0000, 1'b1);
      valid_in = 1'b0;
      edge_then();

      // Reset mid-stream, asserted between edges.
      valid_in = 1'b1; x = 5; w = 6; b = 1;
      edge_then();
      expect_out("pre_reset", 31, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      expect_out("async_reset", 0, 1'b0);
      valid_in = 1'b0;
      edge_then();
      #2 rst_n = 1'b1;
      edge_then();
      expect_out("post_reset", 0, 1'b0);

      // Randomized traffic with occasional asynchronous reset pulses.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         valid_in = ($urandom_range(99) < 60);
         case ($urandom_range(3))
            0:       begin x = '1; w = '1; b = '1; end
            1:       begin x = '0; w = WIDTH'($urandom); b = WIDTH'($urandom); end
            default: begin x = WIDTH'($urandom); w = WIDTH'($urandom); b = WIDTH'($urandom); end
         endcase
         if ($urandom_range(199) == 0) begin
            #2 rst_n = 1'b0;
            #1;
            expect_out("rand_async_reset", 0, 1'b0);
            #1 rst_n = 1'b1;
         end
      end

      @(negedge clk);
      valid_in = 1'b0;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
